// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : 4-digit common-anode 7-segment scan controller with guard time,
//            16-level PWM brightness and a double-buffered display register.
//            Optional leading-zero suppression with macro LZ_SUPPRESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  bright,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int              PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PH_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]   PH_PRE    = PW'(SCAN_DIV - 2);
    localparam logic [PW-1:0]   GUARD_END = PW'(GUARD_CYC);
    localparam logic [0:0]      ST_GUARD  = 1'b0;
    localparam logic [0:0]      ST_DRIVE  = 1'b1;

    logic [PW-1:0] phase_q, phase_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    pwm_q, pwm_d;
    logic [15:0]   pend_din_q, pend_din_d, act_din_q, act_din_d;
    logic [3:0]    pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [3:0]    pend_br_q, pend_br_d, act_br_q, act_br_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_n_q, dp_n_d;
    logic          fd_q, fd_d;

    logic [0:0]    slot_st;
    logic          frame_end;
    logic          drive_on;
    logic          blank;
    logic [3:0]    nib;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        frame_end = (idx_q == 2'd3) && (phase_q == PH_LAST);
        phase_d   = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
        idx_d     = (phase_q == PH_LAST) ? idx_q + 2'd1 : idx_q;
        slot_st   = (phase_q < GUARD_END) ? ST_GUARD : ST_DRIVE;

        // pwm restarts at 0 on the first DRIVE clock of every slot
        if (phase_d < GUARD_END)
            pwm_d = 4'd0;
        else if (slot_st == ST_DRIVE)
            pwm_d = pwm_q + 4'd1;
        else
            pwm_d = pwm_q;

        pend_din_d = load ? din    : pend_din_q;
        pend_dp_d  = load ? dp_in  : pend_dp_q;
        pend_br_d  = load ? bright : pend_br_q;
        // a load on the commit clock bypasses straight into the active copy
        act_din_d  = frame_end ? pend_din_d : act_din_q;
        act_dp_d   = frame_end ? pend_dp_d  : act_dp_q;
        act_br_d   = frame_end ? pend_br_d  : act_br_q;

        case (idx_q)
            2'd0:    nib = act_din_q[3:0];
            2'd1:    nib = act_din_q[7:4];
            2'd2:    nib = act_din_q[11:8];
            default: nib = act_din_q[15:12];
        endcase

`ifdef LZ_SUPPRESS_EN
        case (idx_q)
            2'd3:    blank = (act_din_q[15:12] == 4'd0);
            2'd2:    blank = (act_din_q[15:8]  == 8'd0);
            2'd1:    blank = (act_din_q[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        drive_on = (slot_st == ST_DRIVE) && (pwm_q <= act_br_q);
        an_d     = drive_on ? ~(4'b0001 << idx_q) : 4'hF;
        seg_d    = (drive_on && !blank) ? hex7(nib) : 7'h7F;
        dp_n_d   = drive_on ? ~act_dp_q[idx_q] : 1'b1;
        // registered one clock early so the pulse lines up with the commit clock
        fd_d     = (idx_q == 2'd3) && (phase_q == PH_PRE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            idx_q      <= 2'd0;
            pwm_q      <= 4'd0;
            pend_din_q <= 16'd0;
            pend_dp_q  <= 4'd0;
            pend_br_q  <= 4'hF;
            act_din_q  <= 16'd0;
            act_dp_q   <= 4'd0;
            act_br_q   <= 4'hF;
            an_q       <= 4'hF;
            seg_q      <= 7'h7F;
            dp_n_q     <= 1'b1;
            fd_q       <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            pwm_q      <= pwm_d;
            pend_din_q <= pend_din_d;
            pend_dp_q  <= pend_dp_d;
            pend_br_q  <= pend_br_d;
            act_din_q  <= act_din_d;
            act_dp_q   <= act_dp_d;
            act_br_q   <= act_br_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_n_q     <= dp_n_d;
            fd_q       <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// Testbench for seg7_scan_ctrl: random loads checked cycle by cycle against a
// reference model computed from elapsed clock count and the display rules.
module tb_seg7_scan_ctrl;

    localparam int DIV   = 32;
    localparam int GC    = 4;
    localparam int FRAME = 4 * DIV;
`ifdef LZ_SUPPRESS_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = 16'd0;
    logic [3:0]  dp_in = 4'd0;
    logic [3:0]  bright = 4'd0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_done;

    seg7_scan_ctrl #(.SCAN_DIV(DIV), .GUARD_CYC(GC)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din), .dp_in(dp_in),
        .bright(bright), .an(an), .seg(seg), .dp_n(dp_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at time %0t", tag, obs, exp, $time);
        end
    endtask

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // model: k = clocks since reset release; pending/active buffers
    int          k;
    logic [15:0] m_pd, m_ad;
    logic [3:0]  m_pp, m_ap, m_pb, m_ab;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;

    function automatic bit is_last(input int s);
        return ((s % DIV) == DIV - 1) && (((s / DIV) % 4) == 3);
    endfunction

    task automatic model_reset();
        k = 0;
        m_pd = 16'd0; m_ad = 16'd0;
        m_pp = 4'd0;  m_ap = 4'd0;
        m_pb = 4'hF;  m_ab = 4'hF;
    endtask

    // pins shown after the clock that leaves counter state s
    task automatic predict(input int s);
        int p, d;
        bit on, blank;
        logic [15:0] hi;
        p  = s % DIV;
        d  = (s / DIV) % 4;
        on = (p >= GC) && (((p - GC) % 16) <= int'(m_ab));
        hi = m_ad >> (4 * d);
        blank = LZ && (d != 0) && (hi == 16'd0);
        e_an = 4'hF;
        if (on) e_an[d] = 1'b0;
        e_seg = (on && !blank) ? seg_tbl[hi[3:0]] : 7'h7F;
        e_dp  = on ? ~m_ap[d] : 1'b1;
        e_fd  = is_last(s + 1);
    endtask

    task automatic do_cycle(input bit ld, input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        load = ld; din = d; dp_in = p; bright = b;
        predict(k);
        if (is_last(k)) begin
            m_ad = ld ? d : m_pd;
            m_ap = ld ? p : m_pp;
            m_ab = ld ? b : m_pb;
        end
        if (ld) begin
            m_pd = d; m_pp = p; m_pb = b;
        end
        @(posedge clk);
        k++;
        @(negedge clk);
        load = 1'b0;
        check("an",         16'(an),         16'(e_an));
        check("seg",        16'(seg),        16'(e_seg));
        check("dp_n",       16'(dp_n),       16'(e_dp));
        check("frame_done", 16'(frame_done), 16'(e_fd));
    endtask

    function automatic logic [3:0] pick_bright();
        case ($urandom_range(3))
            0:       return 4'd0;
            1:       return 4'd7;
            2:       return 4'd15;
            default: return 4'($urandom_range(15));
        endcase
    endfunction

    task automatic check_blank(input string tag);
        check({tag, "_an"},  16'(an),         16'hF);
        check({tag, "_seg"}, 16'(seg),        16'h7F);
        check({tag, "_dp"},  16'(dp_n),       16'h1);
        check({tag, "_fd"},  16'(frame_done), 16'h0);
    endtask

    logic [15:0] dir_din [6] = '{16'h1234, 16'hABCD, 16'h0042, 16'h0300, 16'h0000, 16'hF0F0};
    logic [3:0]  dir_dp  [6] = '{4'b0000, 4'b0000, 4'b0101, 4'b0101, 4'b1111, 4'b1010};
    logic [3:0]  dir_br  [6] = '{4'd15, 4'd15, 4'd0, 4'd7, 4'd15, 4'd3};

    initial begin
        model_reset();
        #12;
        check_blank("reset");
        @(negedge clk);
        rst_n = 1'b1;
        check_blank("release");

        // directed frames: even entries loaded mid-frame after a decoy load,
        // odd entries loaded on the frame_done clock itself
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < FRAME; c++) begin
                int pos;
                pos = k % FRAME;
                if (i % 2 == 0 && pos == 10)
                    do_cycle(1'b1, 16'($urandom), 4'($urandom), pick_bright());
                else if ((i % 2 == 0 && pos == 50) || (i % 2 == 1 && pos == FRAME - 1))
                    do_cycle(1'b1, dir_din[i], dir_dp[i], dir_br[i]);
                else
                    do_cycle(1'b0, 16'd0, 4'd0, 4'd0);
            end
        end

        // randomized frames
        for (int f = 0; f < 20; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                bit ld;
                logic [15:0] rd;
                ld = ($urandom_range(59) == 0) || (is_last(k) && $urandom_range(1) == 1);
                rd = 16'($urandom);
                if ($urandom_range(3) == 0) rd = rd & 16'h00FF;
                do_cycle(ld, rd, 4'($urandom), pick_bright());
            end
        end

        // asynchronous reset in the middle of a DRIVE window at full brightness
        for (int c = 0; c < FRAME; c++)
            do_cycle(is_last(k), 16'h5A5A, 4'b1111, 4'd15);
        while ((k % DIV) != 12)
            do_cycle(1'b0, 16'd0, 4'd0, 4'd0);
        check("pre_reset_an_lit", 16'(an == 4'hF), 16'h0);
        #2 rst_n = 1'b0;
        #1 check_blank("async_reset");
        @(negedge clk);
        check_blank("held_reset");
        model_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++)
            do_cycle(is_last(k) || $urandom_range(40) == 0, 16'($urandom), 4'($urandom), pick_bright());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
